// File: rtl/band_gain_mixer.sv
// Band recombination stage: captures 8 filter-bank outputs, weights each by a programmable gain with a
// serial MAC (one band per clock), then rounds and saturates the sum to one equalized output sample.
module band_gain_mixer #(
    parameter int BAND_W    = 32,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14,
    parameter int COEF_FRAC = 15,
    parameter int OUT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [BAND_W-1:0] y_in_1,
    input  logic signed [BAND_W-1:0] y_in_2,
    input  logic signed [BAND_W-1:0] y_in_3,
    input  logic signed [BAND_W-1:0] y_in_4,
    input  logic signed [BAND_W-1:0] y_in_5,
    input  logic signed [BAND_W-1:0] y_in_6,
    input  logic signed [BAND_W-1:0] y_in_7,
    input  logic signed [BAND_W-1:0] y_in_8,
    input  logic                     in_valid,
    output logic                     ready,
    input  logic                     gain_wr,
    input  logic [2:0]               gain_addr,
    input  logic signed [GAIN_W-1:0] gain_data,
    output logic signed [OUT_W-1:0]  x_out,
    output logic                     out_valid,
    output logic                     overrun,
    input  logic                     ovr_clr
);

    localparam int PROD_W = BAND_W + GAIN_W;
    localparam int ACC_W  = PROD_W + 3;
    localparam int SHIFT  = GAIN_FRAC + COEF_FRAC;

    // IDLE: waiting for strobe | ACC: one band MAC per clock | OUT: round, saturate, publish
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic signed [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1) << GAIN_FRAC;
    localparam logic signed [ACC_W-1:0]  RND_HALF   = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX    = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN    = -(ACC_W'(1) << (OUT_W - 1));
    localparam logic signed [OUT_W-1:0]  OUT_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0]  OUT_MIN    = {1'b1, {(OUT_W-1){1'b0}}};

    logic [1:0]               r_state;
    logic signed [BAND_W-1:0] r_band      [8];
    logic signed [GAIN_W-1:0] r_gain_work [8];
    logic signed [GAIN_W-1:0] r_gain_act  [8];
    logic signed [ACC_W-1:0]  r_acc;
    logic [2:0]               r_idx;
    logic signed [OUT_W-1:0]  r_x_out;
    logic                     r_out_valid;
    logic                     r_overrun;

    logic signed [BAND_W-1:0] w_y         [8];
    logic signed [GAIN_W-1:0] w_gain_next [8];
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_rnd;
    logic signed [ACC_W-1:0]  w_scaled;
    logic signed [OUT_W-1:0]  w_sat;
    logic                     w_idle;

    assign w_y[0] = y_in_1;
    assign w_y[1] = y_in_2;
    assign w_y[2] = y_in_3;
    assign w_y[3] = y_in_4;
    assign w_y[4] = y_in_5;
    assign w_y[5] = y_in_6;
    assign w_y[6] = y_in_7;
    assign w_y[7] = y_in_8;

    assign w_idle = (r_state == S_IDLE);

    // Snapshot uses the post-write gain so a write on the accept edge is seen by that sample.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_gain_next[i] = (gain_wr && (gain_addr == 3'(i))) ? gain_data : r_gain_work[i];
        end
    end

    assign w_prod     = PROD_W'(r_band[r_idx]) * PROD_W'(r_gain_act[r_idx]);
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_rnd  = r_acc + RND_HALF;
    assign w_scaled   = w_acc_rnd >>> SHIFT;

    always_comb begin
        w_sat = w_scaled[OUT_W-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = OUT_MAX;
        end else if (w_scaled < SAT_MIN) begin
            w_sat = OUT_MIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_idx       <= '0;
            r_x_out     <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_band[i]      <= '0;
                r_gain_work[i] <= GAIN_UNITY;
                r_gain_act[i]  <= GAIN_UNITY;
            end
        end else begin
            r_out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_gain_work[i] <= w_gain_next[i];
            end

            if (in_valid && !w_idle) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            r_band[i]     <= w_y[i];
                            r_gain_act[i] <= w_gain_next[i];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    r_x_out     <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready     = w_idle;
    assign x_out     = r_x_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule
